// File: rtl/glyph_blit_ctrl_if.sv
// glyph_blit_ctrl_if: control, glyph ROM and framebuffer write-port signals of the glyph blitter
interface glyph_blit_ctrl_if #(parameter int FB_AW = 17);
  logic start;
  logic [9:0] x0;
  logic [8:0] y0;
  logic opaque;
  logic busy;
  logic done;
  logic [7:0] rom_addr;
  logic rom_pixel;
  logic fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic fb_data;
  logic fb_ready;
  modport master (
    input  start, x0, y0, opaque, rom_pixel, fb_ready,
    output busy, done, rom_addr, fb_we, fb_addr, fb_data
  );
  modport slave (
    output start, x0, y0, opaque, rom_pixel, fb_ready,
    input  busy, done, rom_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/glyph_blit_ctrl.sv
// glyph_blit_ctrl: copies a glyph from ROM into the framebuffer; GLYPH_BLIT_CLIP_EN skips off-screen pixels
module glyph_blit_ctrl #(
  parameter int GLYPH_W = 10,
  parameter int GLYPH_H = 16,
  parameter int FB_W = 320,
  parameter int FB_H = 240,
  parameter int FB_AW = 17
) (
  input logic clk,
  input logic reset,
  glyph_blit_ctrl_if.master bus
);
`ifdef GLYPH_BLIT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [9:0] x_l, xs;
  logic [8:0] y_l, ys;
  logic op_l, pix, last, clip, adv;
  logic [3:0] col, row;
  logic [7:0] idx;
  assign xs = x_l + 10'(col);
  assign ys = y_l + 9'(row);
  assign last = idx == 8'(GLYPH_W * GLYPH_H - 1);
  assign clip = CLIP_EN && (32'(xs) >= FB_W || 32'(ys) >= FB_H);
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.fb_we = state == WRITE;
  assign bus.fb_addr = FB_AW'(32'(ys) * FB_W + 32'(xs));
  assign bus.fb_data = pix;
  assign bus.rom_addr = idx;
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    adv = 1'b0;
    case (state)
      IDLE: nxt = bus.start ? FETCH : IDLE;
      FETCH: nxt = WAIT;
      WAIT: begin
        adv = clip || !(op_l || bus.rom_pixel);
        nxt = !adv ? WRITE : last ? DONE : FETCH;
      end
      WRITE: begin
        adv = bus.fb_ready;
        nxt = !adv ? WRITE : last ? DONE : FETCH;
      end
      default: nxt = IDLE;
    endcase
  end
  // ROM data is captured in WAIT so fb_data stays stable through any stall
  always_ff @(posedge clk) begin
    if (reset) begin
      x_l <= '0;
      y_l <= '0;
      op_l <= 1'b0;
      pix <= 1'b0;
      col <= '0;
      row <= '0;
      idx <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        x_l <= bus.x0;
        y_l <= bus.y0;
        op_l <= bus.opaque;
        col <= '0;
        row <= '0;
        idx <= '0;
      end
      if (state == WAIT) pix <= bus.rom_pixel;
      if (adv) begin
        idx <= idx + 8'd1;
        col <= col == 4'(GLYPH_W - 1) ? 4'd0 : col + 4'd1;
        row <= col == 4'(GLYPH_W - 1) ? row + 4'd1 : row;
      end
    end
  end
endmodule

// File: tb/tb_glyph_blit_ctrl.sv
// tb_glyph_blit_ctrl: randomized blits checked against a per-pixel write-list model
module tb_glyph_blit_ctrl;
`ifdef GLYPH_BLIT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef struct {int addr; bit data;} wr_t;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  bit glyph [160];
  wr_t q[$];
  glyph_blit_ctrl_if #(.FB_AW(17)) bus();
  glyph_blit_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_pixel <= bus.rom_addr < 8'd160 ? glyph[bus.rom_addr] : 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // mode 0: always ready, 1: random ready, 2: five-cycle stall on the first write
  task automatic run_blit(int x, int y, bit op, int mode, int poke_at, int reset_at);
    int cost, n, stalls, stall_left;
    bit done_seen, rdy;
    foreach (glyph[i]) glyph[i] = 1'($urandom_range(0, 1));
    q.delete();
    cost = 1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 10; c++) begin
        int xs, ys;
        bit p;
        p = glyph[r * 10 + c];
        xs = (x + c) % 1024;
        ys = (y + r) % 512;
        if (!(CLIP && (xs >= 320 || ys >= 240)) && (op || p)) begin
          q.push_back('{(ys * 320 + xs) % 131072, p});
          cost += 3;
        end else cost += 2;
      end
    @(negedge clk);
    bus.x0 = 10'(x);
    bus.y0 = 9'(y);
    bus.opaque = op;
    bus.fb_ready = 1'b1;
    bus.start = 1'b1;
    n = 0;
    stalls = 0;
    stall_left = -1;
    done_seen = 1'b0;
    while (!done_seen && n < 3000) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.x0 = 10'(x);
      if (n == poke_at) begin
        bus.start = 1'b1;
        bus.x0 = 10'(x) ^ 10'h155;
      end
      if (reset_at > 0 && n >= reset_at && bus.fb_we) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_fb_we", bus.fb_we, 0);
        check("rst_busy", bus.busy, 0);
        repeat (3) begin
          check("rst_no_done", bus.done, 0);
          @(negedge clk);
        end
        return;
      end
      check("busy", bus.busy, 1);
      if (bus.done) begin
        done_seen = 1'b1;
        check("done_cycle", n, cost + stalls);
      end
      if (bus.fb_we) begin
        if (q.size() == 0) check("extra_write", 1, 0);
        else begin
          check("fb_addr", bus.fb_addr, q[0].addr);
          check("fb_data", bus.fb_data, q[0].data);
        end
        if (mode == 2) begin
          if (stall_left < 0) stall_left = 5;
          rdy = stall_left == 0;
          if (stall_left > 0) stall_left--;
        end else rdy = mode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
        bus.fb_ready = rdy;
        if (rdy) begin
          if (q.size() > 0) void'(q.pop_front());
        end else stalls++;
      end else bus.fb_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!done_seen) check("timeout", 0, 1);
    check("writes_left", q.size(), 0);
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("single_done", bus.done, 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.opaque = 1'b0;
    bus.fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_fb_addr", bus.fb_addr, 0);
    check("rst_fb_data", bus.fb_data, 0);
    reset = 1'b0;
    run_blit(0, 0, 1'b1, 0, 0, 0);
    run_blit(100, 50, 1'b0, 0, 0, 0);
    run_blit(0, 0, 1'b1, 2, 0, 0);
    run_blit(20, 30, 1'b1, 0, 40, 0);
    run_blit(0, 0, 1'b1, 0, 0, 100);
    run_blit(0, 0, 1'b1, 0, 0, 0);
    run_blit(315, 0, 1'b1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    check("reset_wins", bus.busy, 0);
    @(negedge clk);
    check("reset_wins_hold", bus.busy, 0);
    repeat (6) run_blit($urandom_range(0, 310), $urandom_range(0, 224), 1'($urandom_range(0, 1)), 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/glyph_blit_ctrl.md
Name: glyph_blit_ctrl

Overview:
- Sequences the 10x16 sharp-symbol glyph ROM (1-bit pixels, registered read, 1-cycle latency, address = row*10+col) and copies the glyph into the 1-bit display framebuffer at a requested (x0,y0).
- Sits between the note/UI logic, which issues start, and the framebuffer write port, which applies backpressure via fb_ready.
- Supports transparent mode (write only set pixels) and opaque mode (write every pixel).

Parameters:
- GLYPH_W, 10, glyph width in pixels
- GLYPH_H, 16, glyph height in pixels
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- FB_AW, 17, framebuffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a blit; sampled only in IDLE
- x0  in  10  glyph left column; latched on start
- y0  in  9  glyph top row; latched on start
- opaque  in  1  1 = write all pixels, 0 = write set pixels only; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- rom_addr  out  8  glyph ROM address
- rom_pixel  in  1  ROM data, valid the cycle after rom_addr
- fb_we  out  1  framebuffer write request
- fb_addr  out  FB_AW  framebuffer write address
- fb_data  out  1  framebuffer write pixel
- fb_ready  in  1  write accepted on a cycle where fb_we && fb_ready

Behaviour:
- Reset: state IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, col/row/idx=0.
- Reset mid-blit: return to IDLE on the next edge; fb_we=0 the next cycle; no done pulse.
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
  - IDLE: on start, latch x0/y0/opaque, clear col/row/idx, go to FETCH.
  - FETCH (1 cycle): rom_addr=idx; go to WAIT.
  - WAIT (1 cycle): rom_pixel valid. Capture it into a pixel register.
    - If opaque=1 or pixel=1 (and not clipped): go to WRITE.
    - Otherwise the pixel is skipped: advance counters, then go to FETCH, or DONE if this was the last pixel.
  - WRITE: fb_we=1, fb_addr=(y0+row)*FB_W+(x0+col) truncated to FB_AW bits, fb_data=pixel register.
    - Hold fb_we, fb_addr and fb_data stable until fb_ready=1.
    - On accept: advance counters, go to FETCH or DONE.
  - DONE (1 cycle): done=1, busy=1; then IDLE.
- Counters: col wraps GLYPH_W-1 -> 0 and increments row. idx increments every pixel (0..GLYPH_W*GLYPH_H-1). Last pixel is idx=159.
- Arithmetic: the coordinate sum is computed at 10 bits (x) and 9 bits (y) before the multiply. No wrap-around check beyond the optional feature.
- Timing: written pixels take 3 cycles plus stall cycles; skipped pixels take 2 cycles.
- start while busy: ignored, with no effect on the latched values.
- start in the same cycle as reset: reset wins.

Optional Feature:
- Macro: GLYPH_BLIT_CLIP_EN
- Defined: a pixel with x0+col >= FB_W or y0+row >= FB_H is treated as skipped (no fb_we; 2 cycles) regardless of opaque.
- Undefined: no bounds check. An out-of-range pixel is written at the truncated address; the caller guarantees placement.

Test Plan:
- Opaque blit, x0=0, y0=0, fb_ready=1, start at cycle 0 -> first fb_we at cycle 3 with fb_addr=0; 160 writes at addresses 0..9, 320..329, ..., 4800..4809; data matches the glyph; done at cycle 481.
- Transparent blit, x0=100, y0=50, fb_ready=1 -> exactly 56 writes, all fb_data=1; first write fb_addr=50*320+103=16103; done at cycle 377.
- Backpressure: opaque blit, fb_ready held 0 for 5 cycles at the first write -> fb_we/fb_addr/fb_data stable across the stall; done delayed to cycle 486.
- start pulsed at cycle 40 of a running blit with different x0 -> ignored; address sequence unchanged; a single done pulse.
- reset asserted during WRITE at cycle 100 -> fb_we=0 and busy=0 on the next cycle, no done pulse; a new start then runs a full blit correctly.
- With GLYPH_BLIT_CLIP_EN, opaque, x0=315, y0=0 -> only cols 0..4 are written (80 writes); done at 80*3+80*2+1=401. Without the macro -> 160 writes.
